// File: rtl/stream_byte_packer.sv
// stream_byte_packer: packs RATIO narrow valid/ready beats of IN_W bits into
// one wide output word. A beat flagged s_last closes the word early; unused
// upper lanes are zero and m_count gives the number of valid lanes.
// A single output register lets a completing beat load while the previous
// word drains, so throughput is one beat per cycle while m_ready is high.
// Optional feature macro: STREAM_PACKER_KEEP_EN adds the registered m_keep
// lane mask (bit i set when i < m_count).
module stream_byte_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = $clog2(RATIO + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IN_W*RATIO-1:0]   m_data,
  output logic                    m_last,
  output logic [CNT_W-1:0]        m_count
`ifdef STREAM_PACKER_KEEP_EN
  ,
  output logic [RATIO-1:0]        m_keep
`endif
);

  localparam int IDX_W = $clog2(RATIO);
  localparam int W     = IN_W * RATIO;

  logic [W-1:0]     acc;
  logic [IDX_W-1:0] idx;
  logic             out_full;
  logic             s_fire;
  logic             completing;
  logic [W-1:0]     merged;

  // Ready depends only on the output register and m_ready, never on s_valid.
  assign s_ready    = !out_full || m_ready;
  assign m_valid    = out_full;
  assign s_fire     = s_valid && s_ready && !flush_in;
  assign completing = s_last || (idx == IDX_W'(RATIO - 1));

  // Accumulator with the current beat dropped into lane idx; lanes above idx
  // are already zero because acc clears on every completed word.
  always_comb begin
    merged = acc;
    merged[idx*IN_W +: IN_W] = s_data;
  end

  // Lane accumulation, output word load/drain, flush and reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      idx      <= '0;
      out_full <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_count  <= '0;
    end else if (flush_in) begin
      acc      <= '0;
      idx      <= '0;
      out_full <= 1'b0;
    end else begin
      if (out_full && m_ready) begin
        out_full <= 1'b0;
      end
      if (s_fire) begin
        if (completing) begin
          out_full <= 1'b1;
          m_data   <= merged;
          m_last   <= s_last;
          m_count  <= CNT_W'(idx) + CNT_W'(1);
          acc      <= '0;
          idx      <= '0;
        end else begin
          acc      <= merged;
          idx      <= idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef STREAM_PACKER_KEEP_EN
  logic [RATIO-1:0] keep_next;

  // Lane mask for the word being loaded: lanes 0..idx are valid.
  always_comb begin
    keep_next = '0;
    for (int i = 0; i < RATIO; i++) begin
      keep_next[i] = (i <= int'(idx));
    end
  end

  // Keep mask registered alongside the word so it tracks m_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_keep <= '0;
    end else if (!flush_in && s_fire && completing) begin
      m_keep <= keep_next;
    end
  end
`endif

endmodule

// File: tb/tb_stream_byte_packer.sv
// Self-checking bench for stream_byte_packer (IN_W=8, RATIO=4).
// Reference model: a queue of accepted beats forms each word; finished words
// wait in an output queue until downstream takes them.
module tb_stream_byte_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int CNT_W = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  flush_in = 1'b0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [IN_W-1:0]       s_data = '0;
  logic                  s_last = 1'b0;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic [IN_W*RATIO-1:0] m_data;
  logic                  m_last;
  logic [CNT_W-1:0]      m_count;
`ifdef STREAM_PACKER_KEEP_EN
  logic [RATIO-1:0]      m_keep;
`endif

  stream_byte_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush_in (flush_in),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_count  (m_count)
`ifdef STREAM_PACKER_KEEP_EN
    ,
    .m_keep   (m_keep)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          count;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] part_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         post_reset = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model with the
  // handshakes that will fire at the next rising edge, then move past it.
  task automatic cycle();
    bit    rdy;
    word_t w;
    @(negedge clk);
    if (post_reset) begin
      check_val("rst_m_data", m_data, 0);
      check_val("rst_m_count", m_count, 0);
      check_val("rst_m_last", m_last, 0);
`ifdef STREAM_PACKER_KEEP_EN
      check_val("rst_m_keep", m_keep, 0);
`endif
      post_reset = 1'b0;
    end
    rdy = (exp_q.size() == 0) || m_ready;
    check_val("m_valid", m_valid, exp_q.size() != 0);
    check_val("s_ready", s_ready, rdy);
    if (exp_q.size() != 0) begin
      check_val("m_data", m_data, exp_q[0].data);
      check_val("m_last", m_last, exp_q[0].last);
      check_val("m_count", m_count, exp_q[0].count);
`ifdef STREAM_PACKER_KEEP_EN
      check_val("m_keep", m_keep, (64'd1 << exp_q[0].count) - 1);
`endif
    end
    if (reset) begin
      exp_q.delete();
      part_q.delete();
      post_reset = 1'b1;
    end else if (flush_in) begin
      exp_q.delete();
      part_q.delete();
    end else begin
      if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
      if (s_valid && rdy) begin
        part_q.push_back(s_data);
        if (part_q.size() == RATIO || s_last) begin
          w.data = '0;
          foreach (part_q[i]) w.data = w.data | (32'(part_q[i]) << (8 * i));
          w.last  = s_last;
          w.count = part_q.size();
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic l, input logic mr);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    post_reset = 1'b1;

    // Four full beats form one word, visible right after the 4th beat.
    beat(1, 8'h11, 0, 1);
    beat(1, 8'h22, 0, 1);
    beat(1, 8'h33, 0, 1);
    check_val("w4_not_yet", m_valid, 0);
    beat(1, 8'h44, 0, 1);
    check_val("w4_valid", m_valid, 1);
    check_val("w4_data", m_data, 32'h44332211);
    check_val("w4_count", m_count, 4);
    check_val("w4_last", m_last, 0);

    // Early close with s_last.
    beat(1, 8'hAA, 0, 1);
    beat(1, 8'hBB, 1, 1);
    check_val("part_data", m_data, 32'h0000BBAA);
    check_val("part_count", m_count, 2);
    check_val("part_last", m_last, 1);
`ifdef STREAM_PACKER_KEEP_EN
    check_val("part_keep", m_keep, 4'b0011);
`endif

    // Back-to-back beats at full throughput.
    for (int i = 0; i < 8; i++) begin
      beat(1, 8'(i), 0, 1);
      if (i == 3) check_val("bb_w0", m_data, 32'h03020100);
      if (i == 7) check_val("bb_w1", m_data, 32'h07060504);
    end
    beat(0, 8'h00, 0, 1);

    // Stall: word pending with m_ready low.
    for (int i = 1; i <= 4; i++) beat(1, 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      beat(1, 8'h99, 0, 0);
      check_val("stall_s_ready", s_ready, 0);
      check_val("stall_data", m_data, 32'h04030201);
      check_val("stall_count", m_count, 4);
    end
    // m_ready rises together with a completing beat.
    beat(1, 8'h77, 1, 1);
    check_val("reload_valid", m_valid, 1);
    check_val("reload_data", m_data, 32'h00000077);
    check_val("reload_count", m_count, 1);
    beat(0, 8'h00, 0, 1);

    // Flush drops a partial word.
    beat(1, 8'h01, 0, 1);
    beat(1, 8'h02, 0, 1);
    flush_in = 1'b1;
    beat(1, 8'h55, 0, 1);
    flush_in = 1'b0;
    for (int i = 0; i < 4; i++) beat(1, 8'(8'h10 + i), 0, 1);
    check_val("flush_data", m_data, 32'h13121110);
    check_val("flush_count", m_count, 4);
    beat(0, 8'h00, 0, 1);

    // Reset mid-word, then reset with a word pending.
    beat(1, 8'h21, 0, 1);
    beat(1, 8'h22, 0, 1);
    reset = 1'b1;
    beat(0, 8'h00, 0, 0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) beat(1, 8'(8'h40 + i), 0, 0);
    reset = 1'b1;
    beat(0, 8'h00, 0, 0);
    reset = 1'b0;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_s_ready", s_ready, 1);
    for (int i = 0; i < 4; i++) beat(1, 8'(8'h30 + i), 0, 1);
    check_val("rst_realign", m_data, 32'h33323130);
    beat(0, 8'h00, 0, 1);

    // Randomized traffic with occasional early close, stall, flush and reset.
    for (int n = 0; n < 3000; n++) begin
      flush_in = ($urandom_range(0, 49) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      beat($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0);
    end
    flush_in = 1'b0;
    reset    = 1'b0;
    beat(0, 8'h00, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
